// File: rtl/stage_phase_accumulator.sv
// First synth pipeline stage: round-robin per-slot phase accumulators that feed
// the modulator stage with a 16-bit phase, the note-on state and the slot ID.
module stage_phase_accumulator #(
    parameter int unsigned NUM_VOICE_OPERATORS = 256,
    parameter int unsigned ID_WIDTH            = 8
) (
    input  logic                i_Clock,
    input  logic                i_Reset,
    output logic [15:0]         o_Phase,
    output logic                o_NoteOn,
    output logic [ID_WIDTH-1:0] o_VoiceOperator,
    output logic                o_Valid,
    input  logic [ID_WIDTH-1:0] i_ConfigWriteAddr,
    input  logic [15:0]         i_ConfigWriteData,
    input  logic                i_PhaseStepLowWriteEnable,
    input  logic                i_PhaseStepHighWriteEnable,
    input  logic                i_NoteOnWriteEnable
);

    localparam int unsigned ACC_WIDTH   = 32;
    localparam int unsigned PHASE_WIDTH = 16;
    localparam logic [ID_WIDTH-1:0] LAST_SLOT = ID_WIDTH'(NUM_VOICE_OPERATORS - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                r_state;
    logic [ID_WIDTH-1:0]   r_counter;

    // Per-slot state
    logic [ACC_WIDTH-1:0]  r_acc_mem  [NUM_VOICE_OPERATORS];
    logic [ACC_WIDTH-1:0]  r_step_mem [NUM_VOICE_OPERATORS];
    logic [NUM_VOICE_OPERATORS-1:0] r_note_on;
    logic [NUM_VOICE_OPERATORS-1:0] r_retrig;

    // Read stage registers (slot fetched on the previous clock)
    logic                  r_rd_valid;
    logic [ID_WIDTH-1:0]   r_rd_id;
    logic [ACC_WIDTH-1:0]  r_rd_acc;
    logic [ACC_WIDTH-1:0]  r_rd_step;
    logic                  r_rd_note_on;
    logic                  r_rd_retrig;

    logic [ACC_WIDTH-1:0]   w_next_acc;
    logic [PHASE_WIDTH-1:0] w_phase;

    // Slot update: a pending retrigger restarts the phase at zero and loads the step
    always_comb begin
        w_next_acc = r_rd_acc + r_rd_step;
        w_phase    = r_rd_acc[ACC_WIDTH-1 -: PHASE_WIDTH];
        if (r_rd_retrig) begin
            w_next_acc = r_rd_step;
            w_phase    = '0;
        end
    end

    // FSM, slot counter, read stage and registered outputs
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state         <= ST_CLEAR;
            r_counter       <= '0;
            r_rd_valid      <= 1'b0;
            r_rd_id         <= '0;
            r_rd_acc        <= '0;
            r_rd_step       <= '0;
            r_rd_note_on    <= 1'b0;
            r_rd_retrig     <= 1'b0;
            o_Phase         <= '0;
            o_NoteOn        <= 1'b0;
            o_VoiceOperator <= '0;
            o_Valid         <= 1'b0;
        end else begin
            r_counter <= r_counter + ID_WIDTH'(1);
            if ((r_state == ST_CLEAR) && (r_counter == LAST_SLOT)) begin
                r_state <= ST_RUN;
            end

            r_rd_valid   <= (r_state == ST_RUN);
            r_rd_id      <= r_counter;
            r_rd_acc     <= r_acc_mem[r_counter];
            r_rd_step    <= r_step_mem[r_counter];
            r_rd_note_on <= r_note_on[r_counter];
            r_rd_retrig  <= r_retrig[r_counter];

            o_Valid <= r_rd_valid;
            if (r_rd_valid) begin
                o_Phase         <= w_phase;
                o_NoteOn        <= r_rd_note_on;
                o_VoiceOperator <= r_rd_id;
            end else begin
                o_Phase         <= '0;
                o_NoteOn        <= 1'b0;
                o_VoiceOperator <= '0;
            end
        end
    end

    // Slot memories: sweep-clear, writeback of the visited slot, then config writes
    // (config writes come last so a note-on landing on the writeback edge keeps its retrigger)
    always_ff @(posedge i_Clock) begin
        if (!i_Reset) begin
            if (r_state == ST_CLEAR) begin
                r_acc_mem[r_counter]  <= '0;
                r_step_mem[r_counter] <= '0;
                r_note_on[r_counter]  <= 1'b0;
                r_retrig[r_counter]   <= 1'b0;
            end else begin
                if (r_rd_valid) begin
                    r_acc_mem[r_rd_id] <= w_next_acc;
                    r_retrig[r_rd_id]  <= 1'b0;
                end
                if (i_PhaseStepLowWriteEnable) begin
                    r_step_mem[i_ConfigWriteAddr][15:0] <= i_ConfigWriteData;
                end
                if (i_PhaseStepHighWriteEnable) begin
                    r_step_mem[i_ConfigWriteAddr][31:16] <= i_ConfigWriteData;
                end
                if (i_NoteOnWriteEnable) begin
                    r_note_on[i_ConfigWriteAddr] <= i_ConfigWriteData[0];
                    if (i_ConfigWriteData[0] && !r_note_on[i_ConfigWriteAddr]) begin
                        r_retrig[i_ConfigWriteAddr] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_stage_phase_accumulator.sv
// Bench for stage_phase_accumulator: per-visit behavioural model with a
// every-cycle compare, plus directed sequences with literal expectations.
module tb_stage_phase_accumulator;

    localparam int unsigned N   = 256;
    localparam int unsigned IDW = 8;

    logic            i_Clock = 1'b0;
    logic            i_Reset;
    logic [15:0]     o_Phase;
    logic            o_NoteOn;
    logic [IDW-1:0]  o_VoiceOperator;
    logic            o_Valid;
    logic [IDW-1:0]  i_ConfigWriteAddr;
    logic [15:0]     i_ConfigWriteData;
    logic            i_PhaseStepLowWriteEnable;
    logic            i_PhaseStepHighWriteEnable;
    logic            i_NoteOnWriteEnable;

    always #5 i_Clock = ~i_Clock;

    stage_phase_accumulator #(
        .NUM_VOICE_OPERATORS(N),
        .ID_WIDTH(IDW)
    ) dut (
        .i_Clock                    (i_Clock),
        .i_Reset                    (i_Reset),
        .o_Phase                    (o_Phase),
        .o_NoteOn                   (o_NoteOn),
        .o_VoiceOperator            (o_VoiceOperator),
        .o_Valid                    (o_Valid),
        .i_ConfigWriteAddr          (i_ConfigWriteAddr),
        .i_ConfigWriteData          (i_ConfigWriteData),
        .i_PhaseStepLowWriteEnable  (i_PhaseStepLowWriteEnable),
        .i_PhaseStepHighWriteEnable (i_PhaseStepHighWriteEnable),
        .i_NoteOnWriteEnable        (i_NoteOnWriteEnable)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit          v;
        logic [15:0] ph;
        bit          on;
        int          id;
    } vis_t;

    logic [31:0] m_acc  [N];
    logic [31:0] m_step [N];
    bit          m_on   [N];
    bit          m_rt   [N];
    int          m_cnt = 0;
    bit          m_run = 0;
    bit          m_started = 0;
    vis_t        m_d1, m_out, cur;

    // Each edge: visit (or clear) one slot, apply config after the visit, delay result by one more edge
    always @(posedge i_Clock) begin
        if (i_Reset) begin
            m_cnt = 0;
            m_run = 0;
            m_d1.v = 0;
            m_out.v = 0;
            m_started = 1;
        end else begin
            cur.v = 0; cur.ph = '0; cur.on = 0; cur.id = 0;
            if (m_run) begin
                int a;
                cur.v  = 1;
                cur.id = m_cnt;
                cur.on = m_on[m_cnt];
                if (m_rt[m_cnt]) begin
                    cur.ph = '0;
                    m_acc[m_cnt] = m_step[m_cnt];
                    m_rt[m_cnt] = 0;
                end else begin
                    cur.ph = m_acc[m_cnt][31:16];
                    m_acc[m_cnt] = m_acc[m_cnt] + m_step[m_cnt];
                end
                a = int'(i_ConfigWriteAddr);
                if (i_PhaseStepLowWriteEnable)  m_step[a][15:0]  = i_ConfigWriteData;
                if (i_PhaseStepHighWriteEnable) m_step[a][31:16] = i_ConfigWriteData;
                if (i_NoteOnWriteEnable) begin
                    if (i_ConfigWriteData[0] && !m_on[a]) m_rt[a] = 1;
                    m_on[a] = i_ConfigWriteData[0];
                end
            end else begin
                m_acc[m_cnt] = '0;
                m_step[m_cnt] = '0;
                m_on[m_cnt] = 0;
                m_rt[m_cnt] = 0;
                if (m_cnt == N - 1) m_run = 1;
            end
            m_cnt = (m_cnt + 1) % N;
            m_out = m_d1;
            m_d1 = cur;
        end
    end

    // ---------------- monitor / compare ----------------
    logic [15:0] q5[$], q7[$], q9[$];
    logic [16:0] q3[$];
    int          rel_edges = 0;
    bit          seen_valid = 0;
    int          first_valid_at = -1;
    logic [31:0] first_id, first_ph, first_on;

    always @(posedge i_Clock) begin
        if (i_Reset) rel_edges <= 0;
        else rel_edges <= rel_edges + 1;
    end

    always @(negedge i_Clock) begin
        if (m_started) begin
            check("valid", 32'(o_Valid), 32'(m_out.v));
            if (m_out.v) begin
                check("id",     32'(o_VoiceOperator), 32'(m_out.id));
                check("phase",  32'(o_Phase),         32'(m_out.ph));
                check("noteon", 32'(o_NoteOn),        32'(m_out.on));
            end
            if (o_Valid === 1'b1) begin
                if (!seen_valid) begin
                    seen_valid = 1;
                    first_valid_at = rel_edges;
                    first_id = 32'(o_VoiceOperator);
                    first_ph = 32'(o_Phase);
                    first_on = 32'(o_NoteOn);
                end
                if (o_VoiceOperator == 8'd3) q3.push_back({o_NoteOn, o_Phase});
                if (o_VoiceOperator == 8'd5 && o_NoteOn) q5.push_back(o_Phase);
                if (o_VoiceOperator == 8'd9 && o_NoteOn) q9.push_back(o_Phase);
                if (o_VoiceOperator == 8'd7) q7.push_back(o_Phase);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Drive one config write for one edge; caller is away from the clock edge
    task automatic cfg(input logic [IDW-1:0] a, input logic [15:0] d,
                       input bit lo, input bit hi, input bit on);
        i_ConfigWriteAddr          = a;
        i_ConfigWriteData          = d;
        i_PhaseStepLowWriteEnable  = lo;
        i_PhaseStepHighWriteEnable = hi;
        i_NoteOnWriteEnable        = on;
        @(posedge i_Clock);
        #1;
        i_PhaseStepLowWriteEnable  = 1'b0;
        i_PhaseStepHighWriteEnable = 1'b0;
        i_NoteOnWriteEnable        = 1'b0;
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        $display("FAIL %s: wait expired at %0t", name, $time);
    endtask

    // Align to the output of slot 100 so writes land far from slots 3..11
    task automatic wait_id100();
        bit done = 0;
        for (int i = 0; i < 3 * N && !done; i++) begin
            @(negedge i_Clock);
            if (o_Valid === 1'b1 && o_VoiceOperator == 8'd100) done = 1;
        end
        if (!done) timeout_fail("sync_id100");
    endtask

    task automatic wait_count(input int which, input int n);
        bit done = 0;
        int sz;
        for (int i = 0; i < 8 * N && !done; i++) begin
            @(negedge i_Clock);
            sz = (which == 3) ? q3.size() : (which == 5) ? q5.size() :
                 (which == 7) ? q7.size() : q9.size();
            if (sz >= n) done = 1;
        end
        if (!done) timeout_fail($sformatf("wait_q%0d", which));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        i_Reset = 1'b1;
        i_ConfigWriteAddr = '0;
        i_ConfigWriteData = '0;
        i_PhaseStepLowWriteEnable = 1'b0;
        i_PhaseStepHighWriteEnable = 1'b0;
        i_NoteOnWriteEnable = 1'b0;

        @(posedge i_Clock);
        #1 i_Reset = 1'b0;
        @(negedge i_Clock);
        check("rst_valid",  32'(o_Valid), 32'd0);
        check("rst_phase",  32'(o_Phase), 32'd0);
        check("rst_noteon", 32'(o_NoteOn), 32'd0);
        check("rst_id",     32'(o_VoiceOperator), 32'd0);

        // Writes during the clear sweep, after slot 3 was already cleared: must be ignored
        repeat (10) @(negedge i_Clock);
        cfg(8'd3, 16'hFFFF, 1, 1, 1);
        cfg(8'd3, 16'hFFFF, 1, 1, 1);

        for (int i = 0; i < 2 * N && !seen_valid; i++) @(negedge i_Clock);
        if (!seen_valid) timeout_fail("first_valid");
        check("first_valid_latency", 32'(first_valid_at), 32'(N + 2));
        check("first_id",     first_id, 32'd0);
        check("first_phase",  first_ph, 32'd0);
        check("first_noteon", first_on, 32'd0);

        wait_count(3, 2);
        check("clear_slot3_v0", 32'(q3[0]), 32'd0);
        check("clear_slot3_v1", 32'(q3[1]), 32'd0);

        // Slot 5 step 0x0001_0000, slot 9 step 0x8000_0000, slot 7 step 0x0100_0000,
        // slot 11 both halves in one write
        wait_id100();
        q5.delete(); q9.delete();
        cfg(8'd5, 16'h0000, 1, 0, 0);
        cfg(8'd5, 16'h0001, 0, 1, 0);
        cfg(8'd5, 16'h0001, 0, 0, 1);
        cfg(8'd9, 16'h0000, 1, 0, 0);
        cfg(8'd9, 16'h8000, 0, 1, 0);
        cfg(8'd9, 16'h0001, 0, 0, 1);
        cfg(8'd7, 16'h0100, 0, 1, 0);
        cfg(8'd7, 16'h0001, 0, 0, 1);
        cfg(8'd11, 16'h0001, 1, 1, 1);

        wait_count(5, 4);
        wait_count(9, 4);
        check("s5_ph0", 32'(q5[0]), 32'h0);
        check("s5_ph1", 32'(q5[1]), 32'h1);
        check("s5_ph2", 32'(q5[2]), 32'h2);
        check("s5_ph3", 32'(q5[3]), 32'h3);
        check("s9_ph0", 32'(q9[0]), 32'h0);
        check("s9_ph1", 32'(q9[1]), 32'h8000);
        check("s9_ph2", 32'(q9[2]), 32'h0);
        check("s9_ph3", 32'(q9[3]), 32'h8000);

        // Note-off then note-on retriggers slot 5
        wait_id100();
        q5.delete();
        cfg(8'd5, 16'h0000, 0, 0, 1);
        cfg(8'd5, 16'h0001, 0, 0, 1);
        wait_count(5, 2);
        check("s5_retrig_ph0", 32'(q5[0]), 32'h0);
        check("s5_retrig_ph1", 32'(q5[1]), 32'h1);

        // Note-on while already on does not retrigger
        wait_id100();
        q5.delete();
        cfg(8'd5, 16'h0001, 0, 0, 1);
        wait_count(5, 2);
        check("s5_noretrig_ph0", 32'(q5[0]), 32'h2);
        check("s5_noretrig_ph1", 32'(q5[1]), 32'h3);

        // Reset in the middle of RUN
        wait_id100();
        i_Reset = 1'b1;
        @(posedge i_Clock);
        #1 i_Reset = 1'b0;
        q7.delete();
        @(negedge i_Clock);
        check("midrun_reset_valid", 32'(o_Valid), 32'd0);
        wait_count(7, 3);
        check("s7_after_reset_v0", 32'(q7[0]), 32'h0);
        check("s7_after_reset_v1", 32'(q7[1]), 32'h0);
        check("s7_after_reset_v2", 32'(q7[2]), 32'h0);

        repeat (4) @(negedge i_Clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
